mem_port_arbiter: RTL

Shares one single-ported unified memory between the instruction-fetch port (port 0) and the data-access port (port 1) of the CPU. Two-state-plus-response FSM with round-robin grant, address/write-data latching, a registered select output for the datapath's memory-address 2-to-1 mux, and a watchdog that aborts transactions the memory never acknowledges. Sits between the IF/MEM stage memory requesters and the external memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/arb_timeout_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents:
//   arb_state_e : FSM state encoding (IDLE / BUSY / DONE)
//   PORT_IF     : port ID of the instruction-fetch requester (port 0)
//   PORT_MEM    : port ID of the data-access requester (port 1)
//   rr_pick     : round-robin choice between the two request lines
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  // Winner among the active requests. On a tie the port that did not win
  // the previous transaction is chosen. Only meaningful when at least one
  // request is high.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    if (req0 && req1) return ~last_grant;
    return req1 ? PORT_MEM : PORT_IF;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog counter for the arbiter's BUSY state.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : force the count back to zero (has priority over enable)
//   enable_i     : advance the count by one
//   expired_o    : count has reached TIMEOUT-1, i.e. this is the last cycle
//                  the memory is allowed to acknowledge in
module arb_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch
// (port 0) and data access (port 1), with round-robin tie breaking and a
// watchdog that aborts transactions the memory never acknowledges.
//
// Handshake: a requester raises reqN_i and holds it (with a stable command)
// until it sees its one-cycle ackN_o; err_o/rdata_o are valid only in that
// ack cycle. The memory side sees mem_req_o high for the whole BUSY phase
// and answers with a single-cycle mem_ack_i (read data alongside it).
//
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   req0_i, addr0_i              : fetch port request (read only)
//   req1_i, addr1_i, we1_i,
//   wdata1_i                     : data port request
//   ack0_o, ack1_o, err_o,
//   rdata_o                      : completion pulse, timeout flag, read data
//   sel_o                        : current grant, drives the address mux
//   mem_req_o, mem_addr_o,
//   mem_we_o, mem_wdata_o        : latched command to the memory
//   mem_ack_i, mem_rdata_i       : memory completion and read data
//   state_o                      : FSM state for debug/observation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              we1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sel_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        state_o
);

  arb_state_e        state_q;
  logic              last_grant_q;
  logic              sel_q;
  logic              mem_req_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic grant_d;
  logic expired;

  assign grant_d = rr_pick(req0_i, req1_i, last_grant_q);

  // The count stays at zero outside BUSY, so every transaction starts
  // its watchdog from scratch without an explicit clear on grant.
  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != ST_BUSY),
    .enable_i  ((state_q == ST_BUSY) && !mem_ack_i),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_MEM;  // so port 0 wins the first tie
      sel_q        <= PORT_IF;
      mem_req_q    <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_i || req1_i) begin
            sel_q     <= grant_d;
            addr_q    <= grant_d ? addr1_i : addr0_i;
            we_q      <= grant_d & we1_i;
            wdata_q   <= grant_d ? wdata1_i : '0;
            mem_req_q <= 1'b1;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A memory ack in the final watchdog cycle still counts as success.
          if (mem_ack_i || expired) begin
            mem_req_q <= 1'b0;
            ack0_q    <= (sel_q == PORT_IF);
            ack1_q    <= (sel_q == PORT_MEM);
            err_q     <= ~mem_ack_i;
            rdata_q   <= (mem_ack_i && !we_q) ? mem_rdata_i : '0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack0_q       <= 1'b0;
          ack1_q       <= 1'b0;
          last_grant_q <= sel_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign sel_o       = sel_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign state_o     = state_q;

endmodule
